// File: rtl/load_size_unit.sv
// rtl/load_size_unit.sv - multi-cycle load sequencer: one memory read, fixed latency, byte/half/word extract and extend
module load_size_unit #(
    parameter int MEM_LAT     = 1,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  LS,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic [31:0] w_LS,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [1:0]  ls_q;
    logic        sext_q;
    logic        reject;
    logic        accept;
    logic        capture;
    logic [31:0] ext_data;

    always_comb begin
        reject = 1'b0;
        if (LS == 2'b11)
            reject = 1'b1;
        else if (CHECK_ALIGN && (LS == 2'b00) && (addr[1:0] != 2'b00))
            reject = 1'b1;
        else if (CHECK_ALIGN && (LS == 2'b01) && addr[0])
            reject = 1'b1;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !reject) begin
                    accept   = 1'b1;
                    state_nx = READ;
                end
            end
            READ: state_nx = WAIT;
            WAIT: begin
                // cnt==1 marks the cycle in which mem_rdata is valid
                if (cnt == 4'd1) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ext_data = mem_rdata;
        case (ls_q)
            2'b01:   ext_data = {{16{sext_q & mem_rdata[15]}}, mem_rdata[15:0]};
            2'b10:   ext_data = {{24{sext_q & mem_rdata[7]}}, mem_rdata[7:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ls_q     <= 2'b00;
            sext_q   <= 1'b0;
            mem_addr <= 32'd0;
            mem_rd   <= 1'b0;
            w_LS     <= 32'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_nx;
            mem_rd <= accept;
            done   <= 1'b0;
            err    <= 1'b0;
            if (state == IDLE && start) begin
                if (reject) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end else begin
                    ls_q     <= LS;
                    sext_q   <= sign_ext;
                    mem_addr <= addr;
                    cnt      <= LAT;
                end
            end
            if (state == WAIT) begin
                if (capture) begin
                    w_LS <= ext_data;
                    done <= 1'b1;
                    cnt  <= 4'd0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
